// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle arithmetic/logic ops, and
// bit-serial shifts that take one cycle per bit of shift amount.
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      control_sig,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   // Handshake: a transfer happens on a rising edge where valid and ready
   // are both high; the producer holds its payload stable until then.

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] SK_SLL = 2'd0;
   localparam logic [1:0] SK_SRL = 2'd1;
   localparam logic [1:0] SK_SRA = 2'd2;

   logic [1:0]      state_q,   state_d;
   logic [XLEN-1:0] result_q,  result_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] acc_q,     acc_d;
   logic [4:0]      cnt_q,     cnt_d;
   logic [1:0]      kind_q,    kind_d;
   logic [XLEN-1:0] acc_step;

   always_comb begin
      case (kind_q)
         SK_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
         SK_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
         SK_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: acc_step = acc_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      kind_d    = kind_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               illegal_d = 1'b0;
               state_d   = ST_DONE;
               result_d  = '0;
               case (control_sig)
                  4'b0000: result_d = op_a + op_b;
                  4'b1000: result_d = op_a - op_b;
                  4'b0010: result_d[0] = $signed(op_a) < $signed(op_b);
                  4'b0011: result_d[0] = op_a < op_b;
                  4'b0100: result_d = op_a ^ op_b;
                  4'b0110: result_d = op_a | op_b;
                  4'b0111: result_d = op_a & op_b;
                  4'b0001, 4'b0101, 4'b1101: begin
                     kind_d = (control_sig == 4'b0001) ? SK_SLL :
                              (control_sig == 4'b0101) ? SK_SRL : SK_SRA;
                     // A zero shift amount skips the serial phase entirely.
                     if (op_b[4:0] == 5'd0) begin
                        result_d = op_a;
                     end else begin
                        acc_d   = op_a;
                        cnt_d   = op_b[4:0];
                        state_d = ST_SHIFT;
                     end
                  end
                  default: illegal_d = 1'b1;
               endcase
            end
         end
         ST_SHIFT: begin
            acc_d = acc_step;
            cnt_d = cnt_q - 5'd1;
            // Result register only sees the final value, never partial shifts.
            if (cnt_q == 5'd1) begin
               result_d = acc_step;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= 5'd0;
         kind_q    <= SK_SLL;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         kind_q    <= kind_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, random ops against a
// reference function, backpressure, and reset abort during a long shift.
module tb_alu_exec_unit;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      control_sig;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int n_checks;
   int n_errors;

   // expected {illegal, result}
   logic [XLEN:0] exp_q[$];

   typedef struct {
      logic [3:0]      ctrl;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
      logic            ill;
      int              lat;
      int              hold;
   } vec_t;

   vec_t vecs[17];

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .control_sig (control_sig),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] r,
                               input logic il, input int lat, input int hold);
      vec_t v;
      v.ctrl = c; v.a = a; v.b = b; v.res = r; v.ill = il; v.lat = lat; v.hold = hold;
      return v;
   endfunction

   function automatic logic [XLEN:0] ref_op(input logic [3:0] c, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (c)
         4'b0000: return {1'b0, a + b};
         4'b1000: return {1'b0, a - b};
         4'b0001: return {1'b0, a << sh};
         4'b0010: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
         4'b0011: return {1'b0, 31'd0, (a < b)};
         4'b0100: return {1'b0, a ^ b};
         4'b0101: return {1'b0, a >> sh};
         4'b1101: return {1'b0, XLEN'($signed(a) >>> sh)};
         4'b0110: return {1'b0, a | b};
         4'b0111: return {1'b0, a & b};
         default: return {1'b1, {XLEN{1'b0}}};
      endcase
   endfunction

   // ---------------- driver + scoreboard ----------------
   task automatic do_op(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN:0] exp, input int exp_lat, input int hold);
      int n;
      int lat;
      logic ready_seen;
      logic [XLEN:0] e;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_op", in_ready, 1'b1);
      in_valid = 1'b1; control_sig = c; op_a = a; op_b = b;
      exp_q.push_back(exp);
      @(negedge clk);
      in_valid    = 1'b0;
      control_sig = 4'($urandom_range(0, 15));
      op_a        = $urandom;
      op_b        = $urandom;
      lat = 1;
      ready_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) ready_seen = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      check("latency", 64'(lat), 64'(exp_lat));
      check("in_ready_low_while_busy", ready_seen | in_ready, 1'b0);
      e = exp_q.pop_front();
      check("result", result, e[XLEN-1:0]);
      check("illegal", illegal, e[XLEN]);
      check("zero", zero, (e[XLEN-1:0] == '0));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_result", result, e[XLEN-1:0]);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_handshake_valid", out_valid, 1'b0);
      check("post_handshake_ready", in_ready, 1'b1);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [3:0] legal_codes[10];
      logic [3:0] c;
      logic [XLEN-1:0] a, b;
      int lat;
      logic seen_valid;

      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      control_sig = 4'd0; op_a = '0; op_b = '0;

      vecs[0]  = mk(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0);
      vecs[1]  = mk(4'b0000, 32'h00000007, 32'h00000008, 32'h0000000F, 1'b0, 1, 0);
      vecs[2]  = mk(4'b1000, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1, 4);
      vecs[3]  = mk(4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1, 0);
      vecs[4]  = mk(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0);
      vecs[5]  = mk(4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0);
      vecs[6]  = mk(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, 0);
      vecs[7]  = mk(4'b0110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1, 1);
      vecs[8]  = mk(4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 0);
      vecs[9]  = mk(4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 5, 0);
      vecs[10] = mk(4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 5, 2);
      vecs[11] = mk(4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 32, 0);
      vecs[12] = mk(4'b0001, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1, 0);
      vecs[13] = mk(4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1, 2);
      vecs[14] = mk(4'b1001, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1, 0);
      vecs[15] = mk(4'b1101, 32'h7FFFFFF0, 32'h00000021, 32'h3FFFFFF8, 1'b0, 2, 0);
      vecs[16] = mk(4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 0);

      legal_codes[0] = 4'b0000; legal_codes[1] = 4'b1000; legal_codes[2] = 4'b0001;
      legal_codes[3] = 4'b0010; legal_codes[4] = 4'b0011; legal_codes[5] = 4'b0100;
      legal_codes[6] = 4'b0101; legal_codes[7] = 4'b1101; legal_codes[8] = 4'b0110;
      legal_codes[9] = 4'b0111;

      // reset state
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_zero", zero, 1'b1);
      check("rst_illegal", illegal, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // first op right after release
      for (int i = 0; i < 17; i++)
         do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, {vecs[i].ill, vecs[i].res},
               vecs[i].lat, vecs[i].hold);

      for (int i = 0; i < 30; i++) begin
         c = legal_codes[$urandom_range(0, 9)];
         if ($urandom_range(0, 5) == 0) c = 4'b1111;
         a = $urandom;
         b = $urandom;
         if (c == 4'b0001 || c == 4'b0101 || c == 4'b1101) b[4:0] = 5'($urandom_range(0, 9));
         lat = ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && b[4:0] != 5'd0) ?
               int'(b[4:0]) + 1 : 1;
         do_op(c, a, b, ref_op(c, a, b), lat, $urandom_range(0, 2));
      end

      // reset during a long shift aborts the op
      in_valid = 1'b1; control_sig = 4'b0001; op_a = 32'h00000001; op_b = 32'h0000001F;
      @(negedge clk);
      in_valid = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("abort_result_in_reset", result, 32'h0);
      check("abort_valid_in_reset", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      check("abort_never_valid", seen_valid, 1'b0);
      check("abort_result", result, 32'h0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

      do_op(4'b1000, 32'h00000005, 32'h00000003, {1'b0, 32'h00000002}, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand and result width in bits.
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 Port clk SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid SHALL be: input, 1 bit, operation request valid.
REQ-006 Port in_ready SHALL be: output, 1 bit, block can accept a request.
REQ-007 Port control_sig SHALL be: input, 4 bits, ALU operation code as produced by the ALU control stage.
REQ-008 Port op_a SHALL be: input, XLEN bits, first operand.
REQ-009 Port op_b SHALL be: input, XLEN bits, second operand; op_b[4:0] is the shift amount.
REQ-010 Port out_valid SHALL be: output, 1 bit, result valid.
REQ-011 Port out_ready SHALL be: input, 1 bit, consumer accepts the result.
REQ-012 Port result SHALL be: output, XLEN bits, registered operation result.
REQ-013 Port zero SHALL be: output, 1 bit, high when result equals 0.
REQ-014 Port illegal SHALL be: output, 1 bit, high when the completed operation had an unsupported code.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be high only in IDLE; acceptance occurs on a rising edge with in_valid and in_ready both high.
REQ-017 The block SHALL latch control_sig, op_a and op_b at acceptance and ignore these inputs at all other times.
REQ-018 The block SHALL decode: 0000 add; 1000 sub; 0001 sll; 0010 slt (signed); 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and.
REQ-019 Add and sub SHALL wrap modulo 2^XLEN with no overflow indication.
REQ-020 slt and sltu SHALL produce 1 or 0 in bit 0 with all upper bits zero.
REQ-021 For any other code, including 1111, the block SHALL produce result 0 and illegal 1; otherwise illegal is 0.
REQ-022 On acceptance of a non-shift op, the block SHALL compute the result, register it, and go IDLE->DONE; out_valid is high in the next cycle (latency 1).
REQ-023 On acceptance of sll/srl/sra with shamt=0, the block SHALL register op_a unchanged and go IDLE->DONE (latency 1).
REQ-024 On acceptance of sll/srl/sra with shamt>0, the block SHALL load an accumulator with op_a and a 5-bit counter with shamt, and go to SHIFT.
REQ-025 In SHIFT, each cycle SHALL shift the accumulator by one bit (sll: zero fill; srl: zero fill; sra: sign-bit fill) and decrement the counter.
REQ-026 The block SHALL go SHIFT->DONE on the edge where the counter goes from 1 to 0; out_valid rises shamt+1 cycles after acceptance (shamt=31 gives 32).
REQ-027 In DONE, out_valid SHALL be high, and result, zero and illegal SHALL be held stable until out_ready is sampled high.
REQ-028 On the DONE edge with out_ready high, the block SHALL return to IDLE; in_ready rises the next cycle. No new request is accepted in the same edge, so maximum throughput is one op per 2 cycles.
REQ-029 zero SHALL be derived from the registered result only, and be valid whenever out_valid is high.
REQ-030 out_ready while not in DONE SHALL have no effect.

Reset
REQ-031 Assertion of rst_n low SHALL immediately force: state IDLE, in_ready 1 after release, out_valid 0, result 0, zero 1, illegal 0, counter 0.
REQ-032 Reset during SHIFT or DONE SHALL abort the operation with no output handshake, and no partial result SHALL become visible.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Add wrap: control_sig=0000, op_a=FFFFFFFF, op_b=00000001 -> one cycle later out_valid=1, result=00000000, zero=1, illegal=0.
REQ-035 sra multicycle: control_sig=1101, op_a=80000000, op_b=00000004 -> in_ready=0 for 5 cycles; out_valid in cycle 5 with result=F8000000.
REQ-036 Signed compare: slt with op_a=FFFFFFFF, op_b=00000001 -> result=1; sltu with same operands -> result=0, zero=1.
REQ-037 Backpressure: sub with op_a=5, op_b=3, out_ready held 0 for 4 cycles -> result=2 stable and in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-038 Illegal code: control_sig=1111 -> result=0, zero=1, illegal=1, latency 1.
REQ-039 Reset mid-shift: sll with shamt=31, rst_n pulsed low in shift cycle 10 -> out_valid never asserts for that op, result=0, in_ready=1 after release.
